dmem_arbiter: RTL

// - Shares the single DataMemory port between the pipeline MEM stage (cpu_*) and a debug/loader requester (dbg_*).
// - Sits between the MEM stage and DataMemory.
// - Grants at most one access per cycle and returns read data one cycle later, steered to the owner.
// - Issues cpu_stall to freeze the pipeline when the CPU loses arbitration.
// - Bounds CPU priority with a streak counter so the loader cannot starve.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DataMemory port between the pipeline MEM stage (cpu_*)
// and a debug/loader requester (dbg_*). At most one access is granted per cycle. Read data
// returns one cycle later and is steered to whichever requester owned the read.
// The CPU normally wins contention. A streak counter bounds how many contended cycles in a
// row the CPU may win, so the loader cannot be starved.
//
// Optional feature: define DMEM_ARB_STATS_EN to add the saturating conflict_count output.
// It counts the cycles in which both requesters asked for memory.

module dmem_arbiter #(
    parameter int unsigned CPU_MAX_STREAK = 4,
    parameter int unsigned STAT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    // MEM stage side
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    // Debug / loader side
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    // DataMemory side
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] conflict_count
`endif
);

    // A 4-bit streak register covers the legal limit range of 1..15.
    localparam logic [3:0] MaxStreak = 4'(CPU_MAX_STREAK);

    // Reject out-of-range parameters at elaboration time.
    if (CPU_MAX_STREAK < 1 || CPU_MAX_STREAK > 15 || STAT_W < 1) begin : g_bad_param
        $error("dmem_arbiter: CPU_MAX_STREAK must be 1..15 and STAT_W at least 1");
    end

    // The FSM records who owns the read that returns in the current cycle.
    typedef enum logic [1:0] {
        StIdle,
        StRdCpu,
        StRdDbg
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       contended;
    logic       cpu_win;
    logic       dbg_win;

    // Grant decode: the CPU wins unless the dbg side has waited through a full streak.
    // While reset is high, nothing is granted, so no memory access leaks out.
    always_comb begin
        contended = cpu_req & dbg_req;
        cpu_win   = 1'b0;
        dbg_win   = 1'b0;
        if (!reset) begin
            if (cpu_req && (!dbg_req || (streak_q < MaxStreak))) begin
                cpu_win = 1'b1;
            end else if (dbg_req) begin
                dbg_win = 1'b1;
            end
        end
    end

    // Streak next-state: count contended CPU wins; any other cycle restarts the count.
    always_comb begin
        streak_d = 4'd0;
        if (contended && cpu_win) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Streak register.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Steer the winner onto the memory port; an idle port drives all zeros.
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_write = cpu_we;
            mem_read  = ~cpu_we;
        end else if (dbg_win) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_write = dbg_we;
            mem_read  = ~dbg_we;
        end
    end

    // Handshake outputs towards the two requesters.
    always_comb begin
        cpu_stall = cpu_req & ~cpu_win & ~reset;
        dbg_gnt   = dbg_win;
    end

    // FSM state register: drops any outstanding read on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: depends only on this cycle's grant, whatever the current state is.
    // This is what allows back-to-back reads.
    always_comb begin
        state_d = StIdle;
        if (cpu_win && !cpu_we) begin
            state_d = StRdCpu;
        end else if (dbg_win && !dbg_we) begin
            state_d = StRdDbg;
        end
    end

    // FSM outputs: route returning read data to its owner. The other side sees zero.
    // Reset gates the outputs, so a read interrupted by reset never reports valid.
    always_comb begin
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        cpu_rdata  = 32'd0;
        dbg_rdata  = 32'd0;
        if (!reset) begin
            unique case (state_q)
                StRdCpu: begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = mem_rdata;
                end
                StRdDbg: begin
                    dbg_rvalid = 1'b1;
                    dbg_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] conflict_q;

    // Saturating count of cycles in which both sides asked for memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (contended && (conflict_q != '1)) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    assign conflict_count = reset ? '0 : conflict_q;
`endif

    // Sanity: the port is never handed to both requesters in the same cycle.
    a_one_grant: assert property (@(posedge clk) !(cpu_win && dbg_win));

endmodule
